// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button, counter and display signals of the stopwatch controller
interface stopwatch_ctrl_if #(
  parameter int BCD_NUM = 4
);
  logic                    btn_start_stop;
  logic                    btn_lap_clear;
  logic [BCD_NUM-1:0][3:0] cnt_bcds;
  logic                    cnt_incr;
  logic                    cnt_reset;
  logic [BCD_NUM-1:0][3:0] disp_bcds;
  logic                    running;
  logic                    lap_active;
  logic                    overflow;

  // Environment side: buttons and the BCD counter feed the controller.
  modport master (
    output btn_start_stop, btn_lap_clear, cnt_bcds,
    input  cnt_incr, cnt_reset, disp_bcds, running, lap_active, overflow
  );

  // Controller side.
  modport slave (
    input  btn_start_stop, btn_lap_clear, cnt_bcds,
    output cnt_incr, cnt_reset, disp_bcds, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/pause/lap/clear sequencing for a BCD stopwatch
// Prescales clk into count enables, runs the IDLE/RUN/PAUSE machine from
// one-cycle button pulses, and keeps the lap freeze and sticky overflow.
module stopwatch_ctrl #(
  parameter int BCD_NUM  = 4,
  parameter int TICK_DIV = 100000
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                  state;
  logic [PW-1:0]           presc;
  logic [BCD_NUM-1:0][3:0] lap_reg;
  logic [BCD_NUM-1:0][3:0] disp_q;
  logic                    lap_active_q;
  logic                    overflow_q;
  logic                    cnt_reset_q;
  logic                    running_q;
  logic                    tick;
  logic                    all_nines;

  // A count step is due on the last prescaler slot of a RUN cycle; a pause
  // pulse in that cycle does not suppress it.
  assign tick = (state == S_RUN) && (presc == PRESC_LAST);

  // Detect the all-9s counter value that wraps to all-0s on the next step.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < BCD_NUM; i++) begin
      if (sw.cnt_bcds[i] != 4'd9) all_nines = 1'b0;
    end
  end

  // State machine, prescaler, lap register, display and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      presc        <= '0;
      lap_reg      <= '0;
      disp_q       <= '0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      cnt_reset_q  <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      cnt_reset_q <= 1'b0;
      disp_q      <= lap_active_q ? lap_reg : sw.cnt_bcds;

      if (tick && all_nines) overflow_q <= 1'b1;

      // The prescaler only advances in RUN, so a pause keeps the partial period.
      if (state == S_RUN) presc <= tick ? '0 : presc + PW'(1);

      if (sw.btn_start_stop) begin
        case (state)
          S_IDLE: begin
            state     <= S_RUN;
            presc     <= '0;
            running_q <= 1'b1;
          end
          S_RUN: begin
            state     <= S_PAUSE;
            running_q <= 1'b0;
          end
          S_PAUSE: begin
            state     <= S_RUN;
            running_q <= 1'b1;
          end
          default: begin
            state     <= S_IDLE;
            presc     <= '0;
            running_q <= 1'b0;
          end
        endcase
      end else if (sw.btn_lap_clear) begin
        if (state == S_RUN) begin
          if (lap_active_q) begin
            lap_active_q <= 1'b0;
          end else begin
            lap_reg      <= sw.cnt_bcds;
            lap_active_q <= 1'b1;
          end
        end else begin
          // Clear from IDLE or PAUSE: reset the counter and return to IDLE.
          cnt_reset_q  <= 1'b1;
          presc        <= '0;
          lap_active_q <= 1'b0;
          overflow_q   <= 1'b0;
          state        <= S_IDLE;
          running_q    <= 1'b0;
        end
      end
    end
  end

  assign sw.cnt_incr   = tick;
  assign sw.cnt_reset  = cnt_reset_q;
  assign sw.disp_bcds  = disp_q;
  assign sw.running    = running_q;
  assign sw.lap_active = lap_active_q;
  assign sw.overflow   = overflow_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
  localparam int BN   = 2;
  localparam int TD   = 4;
  localparam int MAXV = 99;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_ctrl_if #(.BCD_NUM(BN)) sw ();
  stopwatch_ctrl_if #(.BCD_NUM(BN)) sw1 ();

  stopwatch_ctrl #(.BCD_NUM(BN), .TICK_DIV(TD)) u_dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw)
  );

  stopwatch_ctrl #(.BCD_NUM(BN), .TICK_DIV(1)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .sw   (sw1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Environment BCD counter value (decimal) feeding cnt_bcds.
  int cnt_val;

  // Reference model: mode 0 idle, 1 running, 2 paused; phase counts clk cycles within a step.
  int m_mode;
  int m_phase;
  bit m_lap;
  int m_lapval;
  bit m_ovf;
  bit m_creset;
  int m_disp;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit ss, input bit lc, input bit rst, input int v, input bit incr);
    if (rst) begin
      m_mode = 0; m_phase = 0; m_lap = 0; m_lapval = 0;
      m_ovf = 0; m_creset = 0; m_disp = 0;
      return;
    end
    m_disp   = m_lap ? m_lapval : v;
    m_creset = 0;
    if (incr && v == MAXV) m_ovf = 1;
    if (ss) begin
      if (m_mode == 0) begin
        m_mode = 1; m_phase = 0;
      end else if (m_mode == 1) begin
        m_mode = 2; m_phase = (m_phase + 1) % TD;
      end else begin
        m_mode = 1;
      end
    end else if (lc) begin
      if (m_mode == 1) begin
        if (m_lap) m_lap = 0;
        else begin
          m_lap = 1; m_lapval = v;
        end
        m_phase = (m_phase + 1) % TD;
      end else begin
        m_creset = 1; m_phase = 0; m_lap = 0; m_ovf = 0; m_mode = 0;
      end
    end else if (m_mode == 1) begin
      m_phase = (m_phase + 1) % TD;
    end
  endtask

  // One clock cycle: apply inputs after a falling edge, check, clock, check registered outputs.
  task automatic step(input bit ss, input bit lc, input bit rst);
    bit exp_incr;
    bit d_incr;
    bit d_creset;
    int v;
    reset = rst;
    sw.btn_start_stop = ss;
    sw.btn_lap_clear  = lc;
    v = cnt_val;
    sw.cnt_bcds = to_bcd(v);
    #1;
    exp_incr = (m_mode == 1) && (m_phase == TD - 1);
    chk("cnt_incr", 32'(sw.cnt_incr), 32'(exp_incr));
    d_incr   = sw.cnt_incr;
    d_creset = sw.cnt_reset;
    model_edge(ss, lc, rst, v, exp_incr);
    @(posedge clk);
    if (rst || d_creset) cnt_val = 0;
    else if (d_incr) cnt_val = (cnt_val + 1) % (MAXV + 1);
    @(negedge clk);
    chk("running", 32'(sw.running), 32'(m_mode == 1));
    chk("lap_active", 32'(sw.lap_active), 32'(m_lap));
    chk("overflow", 32'(sw.overflow), 32'(m_ovf));
    chk("cnt_reset", 32'(sw.cnt_reset), 32'(m_creset));
    chk("disp_bcds", 32'(sw.disp_bcds), 32'(to_bcd(m_disp)));
  endtask

  initial begin
    int r;
    bit ss;
    bit lc;
    bit rs;
    reset = 1'b1;
    sw.btn_start_stop  = 1'b0;
    sw.btn_lap_clear   = 1'b0;
    sw.cnt_bcds        = '0;
    sw1.btn_start_stop = 1'b0;
    sw1.btn_lap_clear  = 1'b0;
    sw1.cnt_bcds       = '0;
    cnt_val = 0;
    model_edge(0, 0, 1, 0, 0);
    @(negedge clk);

    // Reset values
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_disp", 32'(sw.disp_bcds), 32'h0);

    // Start at cycle 0, count steps on cycles 4, 8, 12
    step(1, 0, 0);
    chk("t1_running", 32'(sw.running), 32'h1);
    for (int k = 0; k < 12; k++) step(0, 0, 0);
    chk("t1_count", 32'(cnt_val), 32'd3);

    // Pause with the prescaler mid-period, hold, then resume
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0);
    chk("t2_paused_count", 32'(cnt_val), 32'd3);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("t2_no_step_yet", 32'(cnt_val), 32'd3);
    step(0, 0, 0);
    chk("t2_resume_step", 32'(cnt_val), 32'd4);

    // Lap freeze at 12 while counting on to 15, then release
    cnt_val = 12;
    step(0, 1, 0);
    for (int k = 0; k < 40 && cnt_val != 15; k++) step(0, 0, 0);
    chk("t3_count", 32'(cnt_val), 32'd15);
    chk("t3_lap_hold", 32'(sw.disp_bcds), 32'h12);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t3_lap_off", 32'(sw.lap_active), 32'h0);

    // Overflow from 99, then pause and clear
    cnt_val = 99;
    for (int k = 0; k < 20 && sw.overflow !== 1'b1; k++) step(0, 0, 0);
    chk("t4_ovf_set", 32'(sw.overflow), 32'h1);
    chk("t4_wrapped", 32'(cnt_val), 32'd0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    chk("t4_ovf_sticky", 32'(sw.overflow), 32'h1);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("t4_cnt_reset", 32'(sw.cnt_reset), 32'h1);
    chk("t4_ovf_clr", 32'(sw.overflow), 32'h0);
    step(0, 0, 0);
    chk("t4_cnt_reset_1cyc", 32'(sw.cnt_reset), 32'h0);
    step(0, 0, 0);
    chk("t4_disp_zero", 32'(sw.disp_bcds), 32'h0);

    // Both buttons together in RUN: start/stop wins
    step(1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0);
    step(1, 1, 0);
    chk("t5_paused", 32'(sw.running), 32'h0);
    chk("t5_no_lap", 32'(sw.lap_active), 32'h0);
    step(0, 0, 0);

    // Reset while running with lap active
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t6_lap_on", 32'(sw.lap_active), 32'h1);
    step(0, 0, 1);
    chk("t6_running", 32'(sw.running), 32'h0);
    chk("t6_lap", 32'(sw.lap_active), 32'h0);
    chk("t6_disp", 32'(sw.disp_bcds), 32'h0);
    step(0, 0, 0);

    // Randomized buttons, occasional reset and counter preloads near 99
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      ss = (r < 6);
      lc = (r < 2) || (r >= 6 && r < 12);
      rs = (r == 99);
      if ($urandom_range(0, 49) == 0) cnt_val = int'($urandom_range(95, 99));
      step(ss, lc, rs);
    end

    // TICK_DIV=1: a count step on every RUN cycle, none after pausing
    sw.btn_start_stop = 1'b0;
    sw.btn_lap_clear  = 1'b0;
    sw1.btn_start_stop = 1'b1;
    @(negedge clk);
    sw1.btn_start_stop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("d1_incr_run", 32'(sw1.cnt_incr), 32'h1);
      chk("d1_running", 32'(sw1.running), 32'h1);
      @(negedge clk);
    end
    sw1.btn_start_stop = 1'b1;
    #1;
    chk("d1_incr_pause_cycle", 32'(sw1.cnt_incr), 32'h1);
    @(negedge clk);
    sw1.btn_start_stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("d1_incr_paused", 32'(sw1.cnt_incr), 32'h0);
      chk("d1_stopped", 32'(sw1.running), 32'h0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
